// File: rtl/mem_if_pkg.sv
// Shared types for the cache line-fill protocol.
//
// Holds the responder state encoding and the line request/response records
// used by the instruction cache, the data cache and line_fill_responder.
// MEM_LINE_WORDS fixes the line geometry that these types describe.
package mem_if_pkg;

  localparam int MEM_LINE_WORDS = 4;
  localparam int MEM_BEAT_W     = $clog2(MEM_LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ_BURST,
    WRITE_ACK
  } state_e;

  // Word i of a line lives at bits [32i+31:32i].
  typedef logic [MEM_LINE_WORDS-1:0][31:0] line_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    line_t       wdata;
  } line_req_t;

  typedef struct packed {
    logic [31:0]           data;
    logic [MEM_BEAT_W-1:0] beat;
    logic                  last;
    logic                  is_write;
  } line_resp_t;

endpackage

// File: rtl/line_fill_responder_store.sv
// line_store: backing storage for line_fill_responder.
//
// Organised as DEPTH_WORDS/LINE_WORDS rows of one full line each, so a
// whole line is written in a single cycle while reads return one word.
//
// Ports:
//   clock    system clock
//   reset    synchronous active-high; clears only the read data register
//   rd_en    read request; when low the read register loads zero
//   rd_addr  word address to read
//   rd_data  registered read word (valid the cycle after rd_en)
//   we       full-line write enable
//   wr_line  line index to write
//   wr_data  write line; word i at bits [32i+31:32i]
module line_store #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LINE_WORDS  = 4
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0]                       rd_addr,
  output logic [31:0]                                          rd_data,
  input  logic                                                 we,
  input  logic [$clog2(DEPTH_WORDS)-$clog2(LINE_WORDS)-1:0]    wr_line,
  input  logic [32*LINE_WORDS-1:0]                             wr_data
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINES  = DEPTH_WORDS / LINE_WORDS;

  logic [32*LINE_WORDS-1:0] mem [LINES];
  logic [31:0]              rd_data_d, rd_data_q;

  // NOTE: the storage array has no reset branch; clearing thousands of
  // words would block RAM inference and its contents survive reset anyway.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_line] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = mem[rd_addr[ADDR_W-1:OFF_W]][{rd_addr[OFF_W-1:0], 5'b0} +: 32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_fill_responder.sv
// line_fill_responder: memory-side responder for cache line fills.
//
// Accepts one line request at a time, waits LATENCY idle cycles, then
// either streams the line back one word per beat (read refill) or commits
// the whole line and returns a single acknowledge beat (write-back).
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only in IDLE and out of reset
//   req_addr          word address, line offset bits ignored, wraps at DEPTH
//   req_write         1 = write-back, 0 = read refill
//   req_wdata         write line, word i at bits [32i+31:32i]
//   resp_valid/ready  response beat handshake
//   resp_data         read word for this beat, 0 on write acknowledge
//   resp_beat         beat index within the line
//   resp_last         final beat of the response
//   resp_is_write     beat is a write acknowledge
module line_fill_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LINE_WORDS  = MEM_LINE_WORDS,
  parameter int LATENCY     = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  input  logic                          req_write,
  input  logic [32*LINE_WORDS-1:0]      req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_data,
  output logic [$clog2(LINE_WORDS)-1:0] resp_beat,
  output logic                          resp_last,
  output logic                          resp_is_write
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  line_req_t        req_q, req_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_last_q, resp_last_d;
  logic             resp_is_write_q, resp_is_write_d;

  logic              accept;
  logic              wait_done;
  logic              st_rd_en;
  logic [ADDR_W-1:0] st_rd_addr;
  logic              st_we;
  logic [31:0]       st_rd_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    beat_d          = beat_q;
    req_d           = req_q;
    resp_valid_d    = resp_valid_q;
    resp_last_d     = resp_last_q;
    resp_is_write_d = resp_is_write_q;
    wait_done       = 1'b0;
    st_we           = 1'b0;
    st_rd_en        = 1'b0;
    st_rd_addr      = {req_q.addr[ADDR_W-1:OFF_W], beat_q};

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d.addr  = 32'({req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
          req_d.write = req_write;
          req_d.wdata = req_wdata;
          if (LATENCY == 0) begin
            wait_done = 1'b1;
          end else begin
            count_d = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (count_q == '0) begin
          wait_done = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      READ_BURST: begin
        // Re-reading the current word while stalled keeps resp_data stable.
        st_rd_en = 1'b1;
        if (resp_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d      = IDLE;
            beat_d       = '0;
            resp_valid_d = 1'b0;
            resp_last_d  = 1'b0;
            st_rd_en     = 1'b0;
          end else begin
            beat_d      = beat_q + OFF_W'(1);
            resp_last_d = (beat_d == LAST_BEAT);
            st_rd_addr  = {req_q.addr[ADDR_W-1:OFF_W], beat_d};
          end
        end
      end
      WRITE_ACK: begin
        if (resp_ready) begin
          state_d         = IDLE;
          resp_valid_d    = 1'b0;
          resp_last_d     = 1'b0;
          resp_is_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // End of the wait: req_d holds the live request when LATENCY is zero
    // and the captured one otherwise.
    if (wait_done) begin
      if (req_d.write) begin
        st_we           = 1'b1;
        state_d         = WRITE_ACK;
        resp_valid_d    = 1'b1;
        resp_last_d     = 1'b1;
        resp_is_write_d = 1'b1;
      end else begin
        state_d      = READ_BURST;
        beat_d       = '0;
        st_rd_en     = 1'b1;
        st_rd_addr   = {req_d.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        resp_valid_d = 1'b1;
        resp_last_d  = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its _d value from before this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= '0;
      beat_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_last_q     <= 1'b0;
      resp_is_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      beat_q          <= beat_d;
      resp_valid_q    <= resp_valid_d;
      resp_last_q     <= resp_last_d;
      resp_is_write_q <= resp_is_write_d;
    end
  end

  // Captured request is pure datapath and is only consumed after accept.
  always_ff @(posedge clock) begin
    req_q <= req_d;
  end

  // Gating the write with reset makes a reset in the commit cycle drop the
  // whole line rather than let it land.
  line_store #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LINE_WORDS  (LINE_WORDS)
  ) u_store (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (st_rd_en),
    .rd_addr (st_rd_addr),
    .rd_data (st_rd_data),
    .we      (st_we && !reset),
    .wr_line (req_d.addr[ADDR_W-1:OFF_W]),
    .wr_data (req_d.wdata)
  );

  assign resp_valid    = resp_valid_q;
  assign resp_data     = st_rd_data;
  assign resp_beat     = beat_q;
  assign resp_last     = resp_last_q;
  assign resp_is_write = resp_is_write_q;

  // Address bits outside the line index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W], req_addr[OFF_W-1:0],
                              req_q.addr[31:ADDR_W], req_q.addr[OFF_W-1:0]};

endmodule

// File: tb/tb_line_fill_responder.sv
// Self-checking bench for line_fill_responder.
//
// Two instances share the stimulus: dut3 (LATENCY=3) and dut0 (LATENCY=0).
// sel chooses which one sees req_valid and which one's outputs are checked.
module tb_line_fill_responder;

  typedef logic [3:0][31:0] word4_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    word4_t      line;   // write data for writes, expected data for reads
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [127:0] req_wdata;
  logic        resp_ready;

  logic        req_ready, resp_valid, resp_last, resp_is_write;
  logic [31:0] resp_data;
  logic [1:0]  resp_beat;

  logic        rr3, rv3, rl3, rw3, rr0, rv0, rl0, rw0;
  logic [31:0] rd3, rd0;
  logic [1:0]  rb3, rb0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  line_fill_responder #(.DEPTH_WORDS(4096), .LINE_WORDS(4), .LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(rr3), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_ready(resp_ready), .resp_data(rd3),
    .resp_beat(rb3), .resp_last(rl3), .resp_is_write(rw3)
  );

  line_fill_responder #(.DEPTH_WORDS(4096), .LINE_WORDS(4), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(rr0), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_data(rd0),
    .resp_beat(rb0), .resp_last(rl0), .resp_is_write(rw0)
  );

  assign req_ready     = sel ? rr0 : rr3;
  assign resp_valid    = sel ? rv0 : rv3;
  assign resp_data     = sel ? rd0 : rd3;
  assign resp_beat     = sel ? rb0 : rb3;
  assign resp_last     = sel ? rl0 : rl3;
  assign resp_is_write = sel ? rw0 : rw3;

  function automatic word4_t mk(input logic [31:0] w0, w1, w2, w3);
    word4_t l;
    l[0] = w0; l[1] = w1; l[2] = w2; l[3] = w3;
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_beat(input logic [31:0] data, input int beat, input bit last, input bit is_wr);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_beat", 32'(resp_beat), 32'(beat));
    check("resp_data", resp_data, data);
    check("resp_last", 32'(resp_last), 32'(last));
    check("resp_is_write", 32'(resp_is_write), 32'(is_wr));
  endtask

  // Handshakes one request and waits (bounded) for the first response beat.
  task automatic issue_req(input bit wr, input logic [31:0] addr, input word4_t line, input bit hold);
    int lat;
    check("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = line;
    tick();
    if (!hold) req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("first_beat_latency", 32'(lat), sel ? 32'd1 : 32'd4);
  endtask

  word4_t a_line, d80_line, orig100_line, new100_line, c_line, b_line;
  vec_t   tbl [8];
  bit     rdy_pat [8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int     beat_pat [8] = '{0, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    a_line       = mk(32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3);
    d80_line     = mk(32'd11, 32'd22, 32'd33, 32'd44);
    orig100_line = mk(32'h0100_0001, 32'h0100_0002, 32'h0100_0003, 32'h0100_0004);
    new100_line  = mk(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004);
    c_line       = mk(32'hC0C0_0000, 32'hC0C0_0001, 32'hC0C0_0002, 32'hC0C0_0003);
    b_line       = mk(32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);

    tbl[0] = '{wr: 1'b1, addr: 32'h0000_0040, line: a_line};
    tbl[1] = '{wr: 1'b0, addr: 32'h0000_0042, line: a_line};
    tbl[2] = '{wr: 1'b1, addr: 32'h0000_0080, line: d80_line};
    tbl[3] = '{wr: 1'b0, addr: 32'h0000_0080, line: d80_line};
    tbl[4] = '{wr: 1'b1, addr: 32'h0000_0100, line: orig100_line};
    tbl[5] = '{wr: 1'b1, addr: 32'h0000_0FFC, line: c_line};
    tbl[6] = '{wr: 1'b0, addr: 32'h0000_1FFD, line: c_line};   // wraps to 0xFFC
    tbl[7] = '{wr: 1'b0, addr: 32'h0000_0101, line: orig100_line};

    reset      = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;

    // Reset state, during and just after reset, for both instances.
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_resp_beat", 32'(resp_beat), 32'd0);
      check("rst_resp_last", 32'(resp_last), 32'd0);
      check("rst_resp_is_write", 32'(resp_is_write), 32'd0);
    end
    sel   = 1'b0;
    reset = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("post_rst_resp_data", resp_data, 32'd0);
    end
    sel = 1'b0;

    // Table: writes get one ack beat, reads stream four beats, ready held high.
    for (int i = 0; i < 8; i++) begin
      issue_req(tbl[i].wr, tbl[i].addr, tbl[i].line, 1'b0);
      if (tbl[i].wr) begin
        expect_beat(32'd0, 0, 1'b1, 1'b1);
        tick();
      end else begin
        for (int b = 0; b < 4; b++) begin
          expect_beat(tbl[i].line[b], b, b == 3, 1'b0);
          tick();
        end
      end
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
      check("idle_req_ready", 32'(req_ready), 32'd1);
    end

    // Backpressure on beats 1 and 2: eight response cycles, words held.
    issue_req(1'b0, 32'h0000_0042, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      resp_ready = rdy_pat[i];
      expect_beat(a_line[beat_pat[i]], beat_pat[i], beat_pat[i] == 3, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    check("bp_done_resp_valid", 32'(resp_valid), 32'd0);
    check("bp_done_req_ready", 32'(req_ready), 32'd1);

    // req_valid held through a burst: no second accept, nothing queued.
    issue_req(1'b0, 32'h0000_0080, '0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      check("busy_req_ready", 32'(req_ready), 32'd0);
      expect_beat(d80_line[b], b, b == 3, 1'b0);
      tick();
    end
    check("held_req_ready_back", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("held_no_extra_resp", 32'(resp_valid), 32'd0);
    end

    // Reset in the final WAIT cycle of a write to 0x100: write must not land.
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0100;
    req_wdata = new100_line;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstw_resp_valid_in_reset", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rstw_no_ack", 32'(resp_valid), 32'd0);
    end
    issue_req(1'b0, 32'h0000_0100, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      expect_beat(orig100_line[b], b, b == 3, 1'b0);
      tick();
    end
    check("rstw_idle", 32'(resp_valid), 32'd0);

    // LATENCY=0 instance: write line 0x004, then read it back through 0x1004.
    sel = 1'b1;
    #0;
    issue_req(1'b1, 32'h0000_0004, b_line, 1'b0);
    expect_beat(32'd0, 0, 1'b1, 1'b1);
    tick();
    check("l0_idle_after_ack", 32'(resp_valid), 32'd0);
    issue_req(1'b0, 32'h0000_1004, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      expect_beat(b_line[b], b, b == 3, 1'b0);
      tick();
    end
    check("l0_idle_after_read", 32'(resp_valid), 32'd0);
    check("l0_req_ready_after_read", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
